rom_download_ctrl: RTL

- Sits between the data_io byte stream and the SDRAM controller's two write ports in an MCR3 arcade top level.
- Queues each downloaded ROM byte and routes it to port1 (main + sound CPU ROM) or port2 (sprite ROM, merged to 32-bit words).
- Issues toggle-style write requests and waits for each acknowledge.
- Tracks download completion and generates the core reset, including the delayed second reset pulse.

---
 rtl/rom_dl_pkg.sv | 31 +++
 rtl/rom_dl_fifo.sv | 74 +++++++
 rtl/rom_download_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg
//   Shared types and widths for the ROM download controller.
//   dl_entry_t  : one queued download byte with its byte address
//   dl_state_e  : write-issue FSM states
//   dup_byte()  : replicate a byte into both halves of a 16-bit SDRAM word
package rom_dl_pkg;

  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 8;
  localparam int P1_AW   = 23;
  localparam int P2_AW   = 16;
  localparam int PORT_DW = 16;
  localparam int DS_W    = 2;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dl_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } dl_state_e;

  function automatic logic [PORT_DW-1:0] dup_byte(input logic [DATA_W-1:0] b);
    return {b, b};
  endfunction

endpackage

// File: rtl/rom_dl_fifo.sv
// rom_dl_fifo
//   Synchronous show-ahead FIFO of download entries. The head entry is
//   visible combinationally while the FIFO is not empty.
//   Ports:
//     clk_sys, reset_n : clock, synchronous active-low reset
//     push, din        : write request and entry; accepted when not full,
//                        or when full together with a pop
//     pop              : discard the head entry (ignored when empty)
//     head             : current head entry
//     full, empty      : occupancy flags
//   DEPTH must be a power of 2 and at least 2.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_sys,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  dl_entry_t din,
  output dl_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  dl_entry_t   mem_q [DEPTH];
  dl_entry_t   mem_d [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // When full, a push is only taken if the head leaves in the same cycle;
  // the written slot is the one being vacated.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/rom_download_ctrl.sv
// rom_download_ctrl
//   Bridges the data_io ROM byte stream to the two SDRAM write ports of an
//   MCR3 core. Bytes are queued, then routed at pop time: below SP_OFFSET to
//   port1 (CPU ROM), inside the sprite window to port2, anything else is
//   dropped silently. Writes use toggle req/ack handshakes. Also tracks
//   download completion and generates the core reset including the delayed
//   second reset pulse.
//   Ports:
//     clk_sys, reset_n         : clock, synchronous active-low reset
//     ioctl_download/index/wr/addr/dout : data_io download interface
//     reset_req                : user reset request
//     port1_*                  : CPU ROM write port (req/ack toggle)
//     port2_*                  : sprite ROM write port (req/ack toggle)
//     port_we                  : registered ioctl_download
//     rom_loaded               : download fully committed to SDRAM
//     core_reset               : active-high game core reset
//     dl_overflow              : sticky, a byte was lost on a full queue
//     dl_sum                   : byte checksum, only with ROM_DL_CHECKSUM_EN
//   Optional feature macro: ROM_DL_CHECKSUM_EN
//
//   state | meaning
//   IDLE  | waiting for a queued byte; pops head and loads port outputs
//   ISSUE | toggles the selected port request
//   WAIT  | holds until the selected ack matches its request
module rom_download_ctrl
  import rom_dl_pkg::*;
#(
  parameter logic [7:0]        ROM_INDEX  = 8'd0,
  parameter logic [ADDR_W-1:0] SP_OFFSET  = 25'h12000,
  parameter int                SP_BITS    = 17,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [CNT_W-1:0]  RST_HOLD   = 16'hffff
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic               ioctl_wr,
  input  logic [ADDR_W-1:0]  ioctl_addr,
  input  logic [DATA_W-1:0]  ioctl_dout,
  input  logic               reset_req,
  output logic               port1_req,
  input  logic               port1_ack,
  output logic [P1_AW-1:0]   port1_a,
  output logic [DS_W-1:0]    port1_ds,
  output logic [PORT_DW-1:0] port1_d,
  output logic               port2_req,
  input  logic               port2_ack,
  output logic [P2_AW-1:0]   port2_a,
  output logic [DS_W-1:0]    port2_ds,
  output logic [PORT_DW-1:0] port2_d,
  output logic               port_we,
  output logic               rom_loaded,
  output logic               core_reset,
  output logic               dl_overflow
`ifdef ROM_DL_CHECKSUM_EN
  ,
  output logic [15:0]        dl_sum
`endif
);

  // One past the last sprite byte; one bit wider so it cannot wrap.
  localparam logic [ADDR_W:0] SP_END = {1'b0, SP_OFFSET} + ((ADDR_W+1)'(1) << SP_BITS);

  dl_state_e            state_q, state_d;
  logic                 sel_q, sel_d;        // 0: port1, 1: port2
  logic                 p1_req_q, p1_req_d;
  logic                 p2_req_q, p2_req_d;
  logic [P1_AW-1:0]     p1_a_q, p1_a_d;
  logic [DS_W-1:0]      p1_ds_q, p1_ds_d;
  logic [PORT_DW-1:0]   p1_d_q, p1_d_d;
  logic [P2_AW-1:0]     p2_a_q, p2_a_d;
  logic [DS_W-1:0]      p2_ds_q, p2_ds_d;
  logic [PORT_DW-1:0]   p2_d_q, p2_d_d;
  logic                 wr_prev_q, wr_prev_d;
  logic                 dl_prev_q, dl_prev_d;
  logic                 port_we_q, port_we_d;
  logic                 pending_q, pending_d;
  logic                 loaded_q, loaded_d;
  logic                 core_rst_q, core_rst_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  dl_entry_t            fifo_in;
  dl_entry_t            head;
  logic                 dl_rise;
  logic                 dl_fall;
  logic                 to_p1;
  logic                 to_p2;
  logic [16:0]          sp_rel;

  assign dl_rise = ioctl_download & ~dl_prev_q;
  assign dl_fall = ~ioctl_download & dl_prev_q;
  assign push    = ioctl_download && (ioctl_index == ROM_INDEX) && ioctl_wr && !wr_prev_q;
  assign fifo_in = '{addr: ioctl_addr, data: ioctl_dout};

  rom_dl_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (fifo_in),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign to_p1 = (head.addr < SP_OFFSET);
  assign to_p2 = !to_p1 && ({1'b0, head.addr} < SP_END);
  // Low bits of a difference depend only on the low bits of the operands,
  // so the 17-bit offset equals bits [16:0] of the full 25-bit subtraction.
  assign sp_rel = head.addr[16:0] - SP_OFFSET[16:0];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pop      = 1'b0;
    p1_req_d = p1_req_q;
    p2_req_d = p2_req_q;
    p1_a_d   = p1_a_q;
    p1_ds_d  = p1_ds_q;
    p1_d_d   = p1_d_q;
    p2_a_d   = p2_a_q;
    p2_ds_d  = p2_ds_q;
    p2_d_d   = p2_d_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (to_p1) begin
            sel_d   = 1'b0;
            p1_a_d  = head.addr[P1_AW:1];
            p1_ds_d = {head.addr[0], ~head.addr[0]};
            p1_d_d  = dup_byte(head.data);
            state_d = ISSUE;
          end else if (to_p2) begin
            sel_d   = 1'b1;
            p2_a_d  = {sp_rel[14:0], sp_rel[16]};
            p2_ds_d = {sp_rel[15], ~sp_rel[15]};
            p2_d_d  = dup_byte(head.data);
            state_d = ISSUE;
          end
          // Out-of-range entries are consumed without a request.
        end
      end
      ISSUE: begin
        if (sel_q) begin
          p2_req_d = ~p2_req_q;
        end else begin
          p1_req_d = ~p1_req_q;
        end
        state_d = WAIT;
      end
      WAIT: begin
        if (sel_q ? (port2_ack == p2_req_q) : (port1_ack == p1_req_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_prev_d = ioctl_wr;
    dl_prev_d = ioctl_download;
    port_we_d = ioctl_download;
    ovf_d     = ovf_q | (push & fifo_full & ~pop);

    pending_d = pending_q;
    if (dl_rise) begin
      pending_d = 1'b0;
    end else if (dl_fall) begin
      pending_d = 1'b1;
    end

    loaded_d = loaded_q;
    if (dl_rise) begin
      loaded_d = 1'b0;
    end else if (pending_q && fifo_empty && (state_q == IDLE)) begin
      loaded_d = 1'b1;
    end

    // Down-counter restarts on every reset request / unload; hitting 1 on
    // the way down produces the single late reset pulse.
    if (reset_req || !loaded_q) begin
      cnt_d = RST_HOLD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    core_rst_d = reset_req | ~loaded_q | (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      p1_req_q   <= 1'b0;
      p2_req_q   <= 1'b0;
      p1_a_q     <= '0;
      p1_ds_q    <= '0;
      p1_d_q     <= '0;
      p2_a_q     <= '0;
      p2_ds_q    <= '0;
      p2_d_q     <= '0;
      wr_prev_q  <= 1'b0;
      dl_prev_q  <= 1'b0;
      port_we_q  <= 1'b0;
      pending_q  <= 1'b0;
      loaded_q   <= 1'b0;
      core_rst_q <= 1'b1;
      ovf_q      <= 1'b0;
      cnt_q      <= RST_HOLD;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      p1_req_q   <= p1_req_d;
      p2_req_q   <= p2_req_d;
      p1_a_q     <= p1_a_d;
      p1_ds_q    <= p1_ds_d;
      p1_d_q     <= p1_d_d;
      p2_a_q     <= p2_a_d;
      p2_ds_q    <= p2_ds_d;
      p2_d_q     <= p2_d_d;
      wr_prev_q  <= wr_prev_d;
      dl_prev_q  <= dl_prev_d;
      port_we_q  <= port_we_d;
      pending_q  <= pending_d;
      loaded_q   <= loaded_d;
      core_rst_q <= core_rst_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic        accepted;

  assign accepted = push && (!fifo_full || pop);

  always_comb begin
    sum_d = dl_rise ? 16'h0000 : sum_q;
    if (accepted) begin
      sum_d = sum_d + {8'h00, ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign dl_sum = sum_q;
`endif

  assign port1_req   = p1_req_q;
  assign port1_a     = p1_a_q;
  assign port1_ds    = p1_ds_q;
  assign port1_d     = p1_d_q;
  assign port2_req   = p2_req_q;
  assign port2_a     = p2_a_q;
  assign port2_ds    = p2_ds_q;
  assign port2_d     = p2_d_q;
  assign port_we     = port_we_q;
  assign rom_loaded  = loaded_q;
  assign core_reset  = core_rst_q;
  assign dl_overflow = ovf_q;

endmodule
